seg_mux_decoder: RTL and testbench

SEG_MUX_DECODER -- requirements
Module: seg_mux_decoder

---
 rtl/seg_mux_decoder_if.sv | 22 ++
 rtl/seg_mux_decoder.sv | 163 ++++++++++++++++
 tb/tb_seg_mux_decoder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_mux_decoder_if.sv
// Signal bundle between a multiplexed two-digit 7-segment source and its decoder.
// The master side drives the raw pins; the slave side returns the decoded digits.
interface seg_mux_decoder_if;
  logic [6:0] seg_pins_n;
  logic       digit_sel;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       ones_valid;
  logic       tens_valid;
  logic       update;
  logic       illegal;

  modport master (
    output seg_pins_n, digit_sel,
    input  ones, tens, ones_valid, tens_valid, update, illegal
  );

  modport slave (
    input  seg_pins_n, digit_sel,
    output ones, tens, ones_valid, tens_valid, update, illegal
  );
endinterface

// File: rtl/seg_mux_decoder.sv
// Snoops a multiplexed two-digit 7-segment display, debounces each strobed pattern
// and decodes stable hex glyphs into per-digit values with freshness flags.
module seg_mux_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 65535
) (
  input  logic               CLK,
  input  logic               RST,
  seg_mux_decoder_if.slave   bus
);
  localparam logic [3:0]  RUN_MAX     = 4'(STABLE_CYCLES);
  localparam logic [3:0]  RUN_CAPTURE = 4'(STABLE_CYCLES - 1);
  localparam logic [15:0] IDLE_MAX    = 16'(TIMEOUT);

  typedef enum logic {SETTLE, HELD} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  meta_reg, sync_reg, prev_reg;
  logic [7:0]  sample;
  logic [3:0]  run_reg, run_next;
  logic        changed, capture, blank;
  logic        legal_cap, illegal_cap;
  logic [3:0]  dec_digit;
  logic        dec_legal;
  logic        update_reg, illegal_reg;
  logic [3:0]  digit_q [2];
  logic        valid_q [2];

  // Raw pins are active-low; the reset value of the synchronizer is an all-dark ones digit.
  assign sample  = {sync_reg[7], ~sync_reg[6:0]};
  assign changed = (sample != prev_reg);
  assign blank   = (sample[6:0] == 7'h00);

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_reg  <= 8'h7F;
      sync_reg  <= 8'h7F;
      prev_reg  <= 8'h00;
      run_reg   <= 4'd0;
      state_reg <= SETTLE;
    end else begin
      meta_reg  <= {bus.digit_sel, bus.seg_pins_n};
      sync_reg  <= meta_reg;
      prev_reg  <= sample;
      run_reg   <= run_next;
      state_reg <= state_next;
    end
  end

  always_comb begin
    run_next   = run_reg;
    state_next = state_reg;
    capture    = 1'b0;
    if (changed) begin
      run_next = 4'd0;
    end else if (run_reg < RUN_MAX) begin
      run_next = run_reg + 4'd1;
    end
    case (state_reg)
      SETTLE: begin
        if (!changed && (run_reg == RUN_CAPTURE)) begin
          state_next = HELD;
          capture    = 1'b1;
        end
      end
      HELD: begin
        if (changed) begin
          state_next = SETTLE;
        end
      end
      default: state_next = SETTLE;
    endcase
  end

  // Exact-match glyph table; anything else (except blank) is an illegal pattern.
  always_comb begin
    dec_digit = 4'h0;
    dec_legal = 1'b1;
    case (sample[6:0])
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7D: dec_digit = 4'h6;
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h7C: dec_digit = 4'hB;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end

  assign legal_cap   = capture && dec_legal;
  assign illegal_cap = capture && !blank && !dec_legal;

  always_ff @(posedge CLK) begin
    if (RST) begin
      update_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      update_reg  <= legal_cap;
      illegal_reg <= illegal_cap;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      logic [3:0]  digit_reg;
      logic        valid_reg;
      logic [15:0] idle_reg, idle_next;
      logic        selected, hit_legal, hit_illegal, timed_out;

      assign selected    = (gi == 1) ? sample[7] : ~sample[7];
      assign hit_legal   = legal_cap && selected;
      assign hit_illegal = illegal_cap && selected;

      always_comb begin
        idle_next = idle_reg;
        if (hit_legal) begin
          idle_next = 16'd0;
        end else if (idle_reg < IDLE_MAX) begin
          idle_next = idle_reg + 16'd1;
        end
      end

      assign timed_out = (TIMEOUT != 0) && (idle_next == IDLE_MAX);

      // A legal capture wins over an expiring idle count in the same cycle.
      always_ff @(posedge CLK) begin
        if (RST) begin
          digit_reg <= 4'd0;
          valid_reg <= 1'b0;
          idle_reg  <= 16'd0;
        end else begin
          idle_reg <= idle_next;
          if (hit_legal) begin
            digit_reg <= dec_digit;
            valid_reg <= 1'b1;
          end else if (hit_illegal || timed_out) begin
            valid_reg <= 1'b0;
          end
        end
      end

      assign digit_q[gi] = digit_reg;
      assign valid_q[gi] = valid_reg;
    end
  endgenerate

  assign bus.ones       = digit_q[0];
  assign bus.tens       = digit_q[1];
  assign bus.ones_valid = valid_q[0];
  assign bus.tens_valid = valid_q[1];
  assign bus.update     = update_reg;
  assign bus.illegal    = illegal_reg;
endmodule

// File: tb/tb_seg_mux_decoder.sv
// Bench for seg_mux_decoder: directed scenarios plus randomized patterns checked
// against a history-based model of the capture and timeout rules.
module tb_seg_mux_decoder;
  localparam int S  = 4;
  localparam int TO = 20;
  localparam logic [6:0] CODES [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  seg_mux_decoder_if bus ();

  seg_mux_decoder #(.STABLE_CYCLES(S), .TIMEOUT(TO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Model: a pattern is captured at edge t when the samples taken at edges
  // t-2-S .. t-2 are identical and the sample at t-3-S was different.
  logic [7:0] hist [32];
  int         cyc = 100;
  logic [3:0] m_digit [2];
  logic       m_valid [2];
  int         m_last  [2];
  logic       m_upd, m_ill;
  logic [7:0] m_v;
  int         m_idx;
  bit         m_stable;

  function automatic int decode_seg(input logic [6:0] seg);
    for (int i = 0; i < 16; i++) if (CODES[i] == seg) return i;
    return -1;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) hist[i] = 8'h00;
  end

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (RST) begin
      for (int k = 0; k < 3; k++) hist[(cyc - k) % 32] = 8'h00;
      for (int d = 0; d < 2; d++) begin
        m_digit[d] = 4'd0;
        m_valid[d] = 1'b0;
        m_last[d]  = cyc;
      end
      m_upd = 1'b0;
      m_ill = 1'b0;
    end else begin
      hist[cyc % 32] = {bus.digit_sel, ~bus.seg_pins_n};
      m_upd = 1'b0;
      m_ill = 1'b0;
      for (int d = 0; d < 2; d++) if (cyc - m_last[d] >= TO) m_valid[d] = 1'b0;
      m_v = hist[(cyc - 2) % 32];
      m_stable = 1'b1;
      for (int k = 2; k <= 2 + S; k++) if (hist[(cyc - k) % 32] !== m_v) m_stable = 1'b0;
      if (m_stable && (hist[(cyc - 3 - S) % 32] !== m_v) && (m_v[6:0] != 7'h00)) begin
        m_idx = decode_seg(m_v[6:0]);
        if (m_idx >= 0) begin
          m_digit[m_v[7]] = 4'(m_idx);
          m_valid[m_v[7]] = 1'b1;
          m_last[m_v[7]]  = cyc;
          m_upd = 1'b1;
        end else begin
          m_valid[m_v[7]] = 1'b0;
          m_ill = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive(input logic [6:0] seg, input logic sel);
    bus.seg_pins_n = ~seg;
    bus.digit_sel  = sel;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(7'h00, 1'b0);
    repeat (3) tick();
    n_tests++; if (bus.ones !== 4'd0) begin n_fail++; $display("FAIL reset_ones: got %0h expected 0", bus.ones); end
    n_tests++; if (bus.tens !== 4'd0) begin n_fail++; $display("FAIL reset_tens: got %0h expected 0", bus.tens); end
    n_tests++; if (bus.ones_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ones_valid: got %0b expected 0", bus.ones_valid); end
    n_tests++; if (bus.tens_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tens_valid: got %0b expected 0", bus.tens_valid); end
    n_tests++; if (bus.update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %0b expected 0", bus.update); end
    n_tests++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %0b expected 0", bus.illegal); end
    RST = 1'b0;
    repeat (8) tick();
    $display("[TB] reset checked");
  endtask

  task automatic test_capture_ones();
    logic exp_u;
    drive(7'h5B, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      tick();
      exp_u = (k == 6);
      n_tests++;
      if (bus.update !== exp_u) begin
        n_fail++; $display("FAIL capture_latency k=%0d: update got %0b expected %0b", k, bus.update, exp_u);
      end
    end
    n_tests++; if (bus.ones !== 4'd2) begin n_fail++; $display("FAIL capture_ones: got %0h expected 2", bus.ones); end
    n_tests++; if (bus.ones_valid !== 1'b1) begin n_fail++; $display("FAIL capture_ones_valid: got %0b expected 1", bus.ones_valid); end
    n_tests++; if (bus.tens_valid !== 1'b0) begin n_fail++; $display("FAIL capture_tens_valid: got %0b expected 0", bus.tens_valid); end
    $display("[TB] ones capture of 2 checked");
  endtask

  task automatic test_hold_tens();
    int n_upd = 0, n_ill = 0, first = -1;
    drive(7'h71, 1'b1);
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.update === 1'b1) begin n_upd++; if (first < 0) first = k; end
      if (bus.illegal === 1'b1) n_ill++;
    end
    n_tests++; if (n_upd != 1) begin n_fail++; $display("FAIL hold_update_count: got %0d expected 1", n_upd); end
    n_tests++; if (first != 6) begin n_fail++; $display("FAIL hold_update_edge: got %0d expected 6", first); end
    n_tests++; if (n_ill != 0) begin n_fail++; $display("FAIL hold_illegal_count: got %0d expected 0", n_ill); end
    n_tests++; if (bus.tens !== 4'hF) begin n_fail++; $display("FAIL hold_tens: got %0h expected f", bus.tens); end
    n_tests++; if (bus.ones !== 4'd2) begin n_fail++; $display("FAIL hold_ones: got %0h expected 2", bus.ones); end
    $display("[TB] tens hold of F checked");
  endtask

  task automatic test_glitch();
    int n_upd = 0, n_ill = 0;
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) drive(((k / 3) % 2 == 0) ? 7'h06 : 7'h4F, 1'b0);
      tick();
      if (bus.update === 1'b1) n_upd++;
      if (bus.illegal === 1'b1) n_ill++;
    end
    n_tests++; if (n_upd != 0) begin n_fail++; $display("FAIL glitch_update_count: got %0d expected 0", n_upd); end
    n_tests++; if (n_ill != 0) begin n_fail++; $display("FAIL glitch_illegal_count: got %0d expected 0", n_ill); end
    n_tests++; if (bus.ones !== 4'd2) begin n_fail++; $display("FAIL glitch_ones: got %0h expected 2", bus.ones); end
    n_tests++; if (bus.tens !== 4'hF) begin n_fail++; $display("FAIL glitch_tens: got %0h expected f", bus.tens); end
    $display("[TB] short-run toggling checked");
  endtask

  task automatic test_illegal();
    int n_upd = 0, n_ill = 0;
    drive(7'h5B, 1'b0);
    repeat (8) tick();
    n_tests++; if (bus.ones_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_pre_valid: got %0b expected 1", bus.ones_valid); end
    drive(7'h01, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.update === 1'b1) n_upd++;
      if (bus.illegal === 1'b1) n_ill++;
    end
    n_tests++; if (n_ill != 1) begin n_fail++; $display("FAIL illegal_pulse_count: got %0d expected 1", n_ill); end
    n_tests++; if (n_upd != 0) begin n_fail++; $display("FAIL illegal_update_count: got %0d expected 0", n_upd); end
    n_tests++; if (bus.ones_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_valid: got %0b expected 0", bus.ones_valid); end
    n_tests++; if (bus.ones !== 4'd2) begin n_fail++; $display("FAIL illegal_ones_kept: got %0h expected 2", bus.ones); end
    $display("[TB] illegal pattern checked");
  endtask

  task automatic test_timeout();
    logic exp_tv, exp_ov;
    for (int k = 0; k < 40; k++) begin
      if (k == 0) drive(7'h3F, 1'b1);
      else if (k == 8) drive(7'h66, 1'b0);
      else if (k == 16) drive(7'h00, 1'b0);
      tick();
      exp_tv = (k >= 6) && (k < 6 + TO);
      exp_ov = (k >= 14) && (k < 14 + TO);
      n_tests++;
      if (bus.tens_valid !== exp_tv) begin
        n_fail++; $display("FAIL timeout_tens_valid k=%0d: got %0b expected %0b", k, bus.tens_valid, exp_tv);
      end
      n_tests++;
      if (bus.ones_valid !== exp_ov) begin
        n_fail++; $display("FAIL timeout_ones_valid k=%0d: got %0b expected %0b", k, bus.ones_valid, exp_ov);
      end
    end
    n_tests++; if (bus.tens !== 4'd0) begin n_fail++; $display("FAIL timeout_tens_kept: got %0h expected 0", bus.tens); end
    n_tests++; if (bus.ones !== 4'd4) begin n_fail++; $display("FAIL timeout_ones_kept: got %0h expected 4", bus.ones); end
    $display("[TB] idle timeout checked");
  endtask

  task automatic test_reset_mid();
    logic exp_u;
    logic [3:0] exp_o;
    drive(7'h06, 1'b0);
    for (int k = 0; k <= 14; k++) begin
      if (k == 5) RST = 1'b1;
      if (k == 6) RST = 1'b0;
      tick();
      exp_u = (k == 12);
      n_tests++;
      if (bus.update !== exp_u) begin
        n_fail++; $display("FAIL reset_mid_update k=%0d: got %0b expected %0b", k, bus.update, exp_u);
      end
      if (k >= 5) begin
        exp_o = (k >= 12) ? 4'd1 : 4'd0;
        n_tests++;
        if ((bus.ones !== exp_o) || (bus.ones_valid !== (k >= 12)) || (bus.tens !== 4'd0) ||
            (bus.tens_valid !== 1'b0) || (bus.illegal !== 1'b0)) begin
          n_fail++;
          $display("FAIL reset_mid_outputs k=%0d: got ones=%0h ov=%0b tens=%0h tv=%0b ill=%0b expected ones=%0h ov=%0b tens=0 tv=0 ill=0",
                   k, bus.ones, bus.ones_valid, bus.tens, bus.tens_valid, bus.illegal, exp_o, (k >= 12));
        end
      end
    end
    $display("[TB] reset before capture checked");
  endtask

  task automatic test_random();
    logic [6:0] seg;
    int hold, r, fails_here = 0;
    for (int seg_i = 0; seg_i < 160 && fails_here < 20; seg_i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) seg = 7'h00;
      else if (r == 1) seg = 7'($urandom);
      else seg = CODES[$urandom_range(0, 15)];
      drive(seg, 1'($urandom));
      hold = int'($urandom_range(1, 8));
      RST = ($urandom_range(0, 39) == 0);
      for (int h = 0; h < hold; h++) begin
        tick();
        RST = 1'b0;
        n_tests++;
        if ((bus.ones !== m_digit[0]) || (bus.tens !== m_digit[1]) || (bus.ones_valid !== m_valid[0]) ||
            (bus.tens_valid !== m_valid[1]) || (bus.update !== m_upd) || (bus.illegal !== m_ill)) begin
          n_fail++; fails_here++;
          $display("FAIL random_outputs seg=%0d: got o=%0h t=%0h ov=%0b tv=%0b u=%0b i=%0b expected o=%0h t=%0h ov=%0b tv=%0b u=%0b i=%0b",
                   seg_i, bus.ones, bus.tens, bus.ones_valid, bus.tens_valid, bus.update, bus.illegal,
                   m_digit[0], m_digit[1], m_valid[0], m_valid[1], m_upd, m_ill);
        end
        n_tests++;
        if ((bus.update === 1'b1) && (bus.illegal === 1'b1)) begin
          n_fail++; fails_here++;
          $display("FAIL random_exclusive seg=%0d: got update=1 illegal=1 expected not both", seg_i);
        end
      end
    end
    $display("[TB] randomized patterns checked");
  endtask

  initial begin
    drive(7'h00, 1'b0);
    @(negedge CLK);
    test_reset();
    test_capture_ones();
    test_hold_tens();
    test_glitch();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
